float_byte_io: RTL and testbench

//  Byte-serial front/back end for the combinational float unit (subf).

---
 rtl/float_byte_io_if.sv | 20 ++
 rtl/float_byte_io.sv | 129 ++++++++++++
 tb/tb_float_byte_io.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/float_byte_io_if.sv
// Byte-stream handshake bundle between the chip pins and float_byte_io.
// The slave side is the block, the master side is whoever drives the pins.
interface float_byte_io_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte
  );
endinterface

// File: rtl/float_byte_io.sv
// Byte-serial operand loader and result streamer around the float unit.
// Loads a then b LSB-first, waits OP_LAT cycles, streams fs back out.
module float_byte_io #(
  parameter int unsigned OP_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  float_byte_io_if.slave  io,
  output logic [31:0]     fa,
  output logic [31:0]     fb,
  input  logic [31:0]     fs,
  output logic            busy
);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    EXEC,
    SEND
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(OP_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] fb_q, fb_d;
  logic [31:0] res_q, res_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        busy_q, busy_d;
  logic        in_acc;
  logic        out_acc;

  assign in_acc  = in_ready_q & io.in_valid;
  assign out_acc = out_valid_q & io.out_ready;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    res_d      = res_q;
    out_byte_d = out_byte_q;
    unique case (state_q)
      LOAD_A: begin
        if (in_acc) begin
          fa_d[{idx_q, 3'b000} +: 8] = io.in_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_acc) begin
          fb_d[{idx_q, 3'b000} +: 8] = io.in_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = EXEC;
            cnt_d   = 4'd0;
          end
        end
      end
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          res_d      = fs;
          out_byte_d = fs[7:0];
          idx_d      = 2'd0;
          cnt_d      = 4'd0;
          state_d    = SEND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SEND: begin
        if (out_acc) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = LOAD_A;
          end else begin
            out_byte_d = res_q[{idx_q + 2'd1, 3'b000} +: 8];
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    out_valid_d = (state_d == SEND);
    busy_d      = !((state_d == LOAD_A) && (idx_d == 2'd0));
  end

  // FSM state, operands, result and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      fa_q        <= 32'd0;
      fb_q        <= 32'd0;
      res_q       <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      busy_q      <= busy_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_byte  = out_byte_q;
  assign fa           = fa_q;
  assign fb           = fb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_float_byte_io.sv
// Directed bench for float_byte_io with an expected-byte scoreboard.
// A second instance with OP_LAT=3 checks the result latency.
module tb_float_byte_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fa, fb, fs;
  logic [31:0] fa3, fb3, fs3;
  logic        busy, busy3;

  float_byte_io_if bus ();
  float_byte_io_if bus3 ();

  always #5 clk = ~clk;

  float_byte_io u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus),
    .fa    (fa),
    .fb    (fb),
    .fs    (fs),
    .busy  (busy)
  );

  float_byte_io #(.OP_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus3),
    .fa    (fa3),
    .fb    (fb3),
    .fs    (fs3),
    .busy  (busy3)
  );

  // Stand-in for subf: exact for the directed vectors, and an
  // arbitrary but bit-exact function for any other operand pair.
  function automatic logic [31:0] subf(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a == b) return 32'h0;
    if (a == 32'h3FC00000 && b == 32'h3F000000) return 32'h3F800000;
    return a ^ b;
  endfunction

  always_comb fs  = subf(fa, fb);
  always_comb fs3 = subf(fa3, fb3);

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    else cyc();
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input bit keep);
    logic [31:0] r;
    r = subf(a, b);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    if (!keep) bus.in_valid = 1'b0;
    check("fa_after_load", fa, a);
    check("fb_after_load", fb, b);
  endtask

  task automatic recv(input bit chk_noin, input int stall_at);
    int t;
    logic [7:0] e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!bus.out_valid && t < 100) begin
        if (chk_noin) check("in_ready_exec", 32'(bus.in_ready), 32'd0);
        if (chk_noin) bus.in_byte = bus.in_byte + 8'd1;
        cyc();
        t++;
      end
      if (t >= 100) begin
        check("out_valid_timeout", 32'd0, 32'd1);
      end else if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q[0];
        if (k == stall_at) begin
          bus.out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            cyc();
            check("stall_byte", 32'(bus.out_byte), 32'(e));
            check("stall_valid", 32'(bus.out_valid), 32'd1);
          end
          bus.out_ready = 1'b1;
        end
        if (chk_noin) check("in_ready_send", 32'(bus.in_ready), 32'd0);
        check("out_byte", 32'(bus.out_byte), 32'(exp_q.pop_front()));
        if (chk_noin) bus.in_byte = bus.in_byte + 8'd1;
        cyc();
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] exp3;
    int n;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_byte    = 8'h00;
    bus.out_ready  = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_byte   = 8'h00;
    bus3.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_byte", 32'(bus.out_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fa", fa, 32'd0);
    check("rst_fb", fb, 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1.5 - 0.5
    send_op(32'h3FC00000, 32'h3F000000, 1'b0);
    check("busy_exec", 32'(busy), 32'd1);
    recv(1'b0, -1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // a == b, busy drops after the last byte
    send_op(32'h40490FDB, 32'h40490FDB, 1'b0);
    recv(1'b0, -1);
    check("busy_after_send", 32'(busy), 32'd0);

    // stall at byte 2
    send_op(32'h3FC00000, 32'h3F000000, 1'b0);
    recv(1'b0, 2);

    // continuous input during EXEC/SEND is not consumed
    send_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    bus.in_byte = 8'hA0;
    recv(1'b1, -1);
    bus.in_valid = 1'b0;
    check("fa_held", fa, 32'h12345678);
    check("fb_held", fb, 32'h9ABCDEF0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
    check("busy_back", 32'(busy), 32'd0);

    // reset after 2 bytes of b
    for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1));
    send_byte(8'h55);
    send_byte(8'h66);
    bus.in_valid = 1'b0;
    check("busy_partial", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fa", fa, 32'd0);
    check("mid_rst_fb", fb, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_byte", 32'(bus.out_byte), 32'd0);
    #1;
    rst_n = 1'b1;
    cyc();
    send_op(32'h3FC00000, 32'h3F000000, 1'b0);
    recv(1'b0, -1);

    // a few arbitrary operand pairs
    for (int j = 0; j < 3; j++) begin
      ra = $urandom;
      rb = $urandom;
      send_op(ra, rb, 1'b0);
      recv(1'b0, -1);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // OP_LAT=3 latency on the second instance
    ra = 32'h3FC00000;
    rb = 32'h3F000000;
    for (int i = 0; i < 8; i++) begin
      bus3.in_valid = 1'b1;
      bus3.in_byte  = (i < 4) ? ra[8*i +: 8] : rb[8*(i-4) +: 8];
      check("lat3_in_ready", 32'(bus3.in_ready), 32'd1);
      cyc();
    end
    bus3.in_valid = 1'b0;
    n = 0;
    while (!bus3.out_valid && n < 20) begin
      cyc();
      n++;
    end
    check("lat3_edges", 32'(n), 32'd3);
    exp3 = 32'h3F800000;
    for (int k = 0; k < 4; k++) begin
      check("lat3_byte", 32'(bus3.out_byte), 32'(exp3[8*k +: 8]));
      cyc();
    end
    check("lat3_done", 32'(bus3.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
